// File: rtl/frame_reader.sv
// Frame buffer scan-out: reads WORDS words from address 0 and streams them as 1-bit pixels, MSB first,
// over valid/ready. A 2-entry word FIFO with read credits covers memory latency and downstream stalls.
module frame_reader #(
  parameter int WORDS  = 38400,
  parameter int ADR_W  = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iGo,
  output logic              oBusy,
  output logic              oDone,
  output logic [ADR_W-1:0]  oAdr,
  output logic              oRdEn,
  input  logic [DATA_W-1:0] iRdData,
  output logic              oPix,
  output logic              oPixVld,
  input  logic              iPixRdy,
  output logic              oSof,
  output logic              oEof
);

  localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(WORDS - 1);
  localparam logic [IDX_W-1:0] TOP_BIT  = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

  // A memory word travels with the frame-boundary flags of its address.
  typedef struct packed {
    logic              first;
    logic              last;
    logic [DATA_W-1:0] data;
  } word_t;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0] pipe_first_q, pipe_first_d;
  logic [RD_LAT-1:0] pipe_last_q, pipe_last_d;
  word_t             fifo_mem_q [2];
  logic              fifo_wr_q, fifo_wr_d;
  logic              fifo_rd_q, fifo_rd_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  word_t             ser_q, ser_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              ser_vld_q, ser_vld_d;

  logic       rd_en, arr_vld, xfer, last_bit, need_load, from_fifo, load, push, pop;
  logic       sof, eof;
  logic [2:0] in_flight;
  word_t      arr_word, fifo_head;

  // Credits: a read may issue only while in-flight reads plus queued words stay below 2.
  assign in_flight = 3'($countones(pipe_vld_q));
  assign rd_en     = (state_q == FETCH) && ((in_flight + {1'b0, fifo_cnt_q}) < 3'd2);

  assign arr_vld   = pipe_vld_q[RD_LAT-1];
  assign arr_word  = '{first: pipe_first_q[RD_LAT-1], last: pipe_last_q[RD_LAT-1], data: iRdData};
  assign fifo_head = fifo_mem_q[fifo_rd_q];

  assign xfer      = ser_vld_q && iPixRdy;
  assign last_bit  = (bit_idx_q == '0);
  assign need_load = !ser_vld_q || (xfer && last_bit);
  assign from_fifo = (fifo_cnt_q != 2'd0);
  assign load      = need_load && (from_fifo || arr_vld);
  assign pop       = load && from_fifo;
  // Returning data bypasses the FIFO when the serializer takes it straight away.
  assign push      = arr_vld && !(load && !from_fifo);

  assign sof = ser_vld_q && ser_q.first && (bit_idx_q == TOP_BIT);
  assign eof = ser_vld_q && ser_q.last && last_bit;

  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oAdr    = adr_q;
  assign oRdEn   = rd_en;
  assign oPixVld = ser_vld_q;
  assign oPix    = ser_vld_q && ser_q.data[bit_idx_q];
  assign oSof    = sof;
  assign oEof    = eof;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can leave a latch behind.
    state_d      = state_q;
    adr_d        = adr_q;
    pipe_vld_d   = pipe_vld_q;
    pipe_first_d = pipe_first_q;
    pipe_last_d  = pipe_last_q;
    fifo_wr_d    = fifo_wr_q ^ push;
    fifo_rd_d    = fifo_rd_q ^ pop;
    fifo_cnt_d   = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    ser_d        = ser_q;
    bit_idx_d    = bit_idx_q;
    ser_vld_d    = ser_vld_q;

    unique case (state_q)
      IDLE:  if (iGo) begin
               state_d = FETCH;
               adr_d   = '0;
             end
      FETCH: if (rd_en) begin
               if (adr_q == LAST_ADR) state_d = DRAIN;
               else                   adr_d   = adr_q + ADR_W'(1);
             end
      DRAIN: if (xfer && eof) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);

    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i]   = pipe_vld_q[i-1];
      pipe_first_d[i] = pipe_first_q[i-1];
      pipe_last_d[i]  = pipe_last_q[i-1];
    end
    pipe_vld_d[0]   = rd_en;
    pipe_first_d[0] = (adr_q == '0);
    pipe_last_d[0]  = (adr_q == LAST_ADR);

    if (load) begin
      ser_d     = from_fifo ? fifo_head : arr_word;
      bit_idx_d = TOP_BIT;
      ser_vld_d = 1'b1;
    end else if (xfer) begin
      bit_idx_d = bit_idx_q - IDX_W'(1);
      if (last_bit) ser_vld_d = 1'b0;
    end
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      adr_q        <= '0;
      pipe_vld_q   <= '0;
      pipe_first_q <= '0;
      pipe_last_q  <= '0;
      fifo_wr_q    <= 1'b0;
      fifo_rd_q    <= 1'b0;
      fifo_cnt_q   <= 2'd0;
      ser_q        <= '0;
      bit_idx_q    <= '0;
      ser_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      adr_q        <= adr_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_first_q <= pipe_first_d;
      pipe_last_q  <= pipe_last_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_rd_q    <= fifo_rd_d;
      fifo_cnt_q   <= fifo_cnt_d;
      ser_q        <= ser_d;
      bit_idx_q    <= bit_idx_d;
      ser_vld_q    <= ser_vld_d;
    end
  end

  // NOTE: FIFO storage is only read when fifo_cnt_q says it holds a word, so it carries no reset.
  always_ff @(posedge iClk) begin
    if (push) fifo_mem_q[fifo_wr_q] <= arr_word;
  end

  always_ff @(posedge iClk) begin
    if (iRst_n) begin
      assert (!(push && !pop && (fifo_cnt_q == 2'd2)))
        else $error("frame_reader: word FIFO written while full");
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader on a 4-word frame (32 pixels) with a 1-cycle memory model.
module tb_frame_reader;

  localparam int WORDS  = 4;
  localparam int TOTAL  = WORDS * 8;
  localparam int RD_LAT = 1;
  localparam logic [7:0] MEM [WORDS] = '{8'h24, 8'h01, 8'hC5, 8'h3A};

  logic        clk;
  logic        rst_n;
  logic        iGo;
  logic        iPixRdy;
  logic [7:0]  iRdData;
  logic        oBusy, oDone, oRdEn, oPix, oPixVld, oSof, oEof;
  logic [15:0] oAdr;

  frame_reader #(.WORDS(WORDS), .ADR_W(16), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
    .iClk    (clk),
    .iRst_n  (rst_n),
    .iGo     (iGo),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oAdr    (oAdr),
    .oRdEn   (oRdEn),
    .iRdData (iRdData),
    .oPix    (oPix),
    .oPixVld (oPixVld),
    .iPixRdy (iPixRdy),
    .oSof    (oSof),
    .oEof    (oEof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: data for an accepted read appears one cycle later; garbage otherwise.
  logic       m_vld;
  logic [1:0] m_adr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= 1'b0;
      m_adr <= 2'd0;
    end else begin
      m_vld <= oRdEn;
      m_adr <= oAdr[1:0];
    end
  end
  assign iRdData = m_vld ? MEM[m_adr] : 8'hEE;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc, rd_cnt, pix_cnt, done_cnt, first_rd_cyc, first_vld_cyc, eof_cyc, done_cyc;
  int max_out, busy_c1;
  int adr_over = 0;
  logic [15:0] first_rd_adr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  function automatic logic exp_bit(input int p);
    logic [7:0] w;
    if (p < 0 || p >= TOTAL) return 1'b0;
    w = MEM[p / 8];
    return w[7 - (p % 8)];
  endfunction

  task automatic reset_frame();
    rd_cnt        = 0;
    pix_cnt       = 0;
    done_cnt      = 0;
    first_rd_cyc  = -1;
    first_rd_adr  = 16'hFFFF;
    first_vld_cyc = -1;
    eof_cyc       = -1;
    done_cyc      = -1;
    max_out       = 0;
    busy_c1       = 0;
  endtask

  // One cycle: drive inputs at the falling edge, sample outputs just after.
  task automatic tick(input logic go, input logic rdy, input logic go_on_done);
    int outst;
    @(negedge clk);
    iGo     = go | (go_on_done & oDone);
    iPixRdy = rdy;
    #1;
    cyc++;
    if (cyc == 1) busy_c1 = int'(oBusy);
    if (oAdr > 16'(WORDS - 1)) adr_over++;
    if (oRdEn) begin
      rd_cnt++;
      if (first_rd_cyc < 0) begin
        first_rd_cyc = cyc;
        first_rd_adr = oAdr;
      end
    end
    if (oPixVld && first_vld_cyc < 0) first_vld_cyc = cyc;
    outst = rd_cnt - (pix_cnt / 8 + (oPixVld ? 1 : 0));
    if (outst > max_out) max_out = outst;
    if (oDone) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (oPixVld && iPixRdy) begin
      chk("pix", oPix, exp_bit(pix_cnt));
      chk("sof", oSof, pix_cnt == 0);
      chk("eof", oEof, pix_cnt == TOTAL - 1);
      if (oEof) eof_cyc = cyc;
      pix_cnt++;
    end
  endtask

  task automatic start_frame();
    reset_frame();
    cyc = -1;
    tick(1'b1, 1'b1, 1'b0);
  endtask

  task automatic run_frame(input logic use_pat, input logic stall, input logic go_fetch,
                           input logic go_done);
    int          budget;
    int          stall_left;
    logic        rdy;
    logic        stalled;
    logic [15:0] pat;
    pat        = 16'b1011_0111_0110_1101;
    stall_left = stall ? 20 : 0;
    budget     = 400;
    while (done_cnt == 0 && budget > 0) begin
      budget--;
      rdy     = use_pat ? pat[(cyc + 1) % 16] : 1'b1;
      stalled = 1'b0;
      if (stall_left > 0 && pix_cnt == 5) begin
        rdy     = 1'b0;
        stalled = 1'b1;
        stall_left--;
      end
      tick(go_fetch && (cyc + 1 == 2), rdy, go_done);
      if (stalled) begin
        chk("stall_vld", oPixVld, 1);
        chk("stall_pix", oPix, exp_bit(5));
        chk("stall_sof", oSof, 0);
        chk("stall_eof", oEof, 0);
        chk("stall_rden", oRdEn, 0);
        chk("stall_reads", rd_cnt, 3);
      end
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, oBusy, 0);
    chk({tag, "_done"}, oDone, 0);
    chk({tag, "_adr"}, oAdr, 0);
    chk({tag, "_rden"}, oRdEn, 0);
    chk({tag, "_pix"}, oPix, 0);
    chk({tag, "_vld"}, oPixVld, 0);
    chk({tag, "_sof"}, oSof, 0);
    chk({tag, "_eof"}, oEof, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    iGo     = 1'b0;
    iPixRdy = 1'b0;
    cyc     = 0;
    reset_frame();
    repeat (2) @(negedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
    chk("idle_busy", oBusy, 0);

    // Frame A: downstream always ready.
    start_frame();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("a_first_rd_cyc", first_rd_cyc, 1);
    chk("a_first_rd_adr", first_rd_adr, 0);
    chk("a_first_vld_cyc", first_vld_cyc, 2 + RD_LAT);
    chk("a_pixels", pix_cnt, TOTAL);
    chk("a_eof_cyc", eof_cyc, 2 + RD_LAT + TOTAL - 1);
    chk("a_done_cyc", done_cyc, eof_cyc + 1);
    chk("a_done_cnt", done_cnt, 1);
    chk("a_done_busy", oBusy, 1);
    chk("a_reads", rd_cnt, WORDS);
    chk("a_max_outstanding", max_out, 2);

    // Frame B: iGo back-to-back after oDone, stall at pixel 5, gappy ready, stray iGo pulses.
    start_frame();
    chk("gap_busy_low", oBusy, 0);
    run_frame(1'b1, 1'b1, 1'b1, 1'b1);
    chk("b_busy_c1", busy_c1, 1);
    chk("b_first_rd_cyc", first_rd_cyc, 1);
    chk("b_first_rd_adr", first_rd_adr, 0);
    chk("b_first_vld_cyc", first_vld_cyc, 2 + RD_LAT);
    chk("b_pixels", pix_cnt, TOTAL);
    chk("b_done_cyc", done_cyc, eof_cyc + 1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      chk("b_idle_after_done", oBusy, 0);
    end
    chk("b_done_cnt", done_cnt, 1);
    chk("b_reads", rd_cnt, WORDS);
    chk("b_max_outstanding", max_out, 2);

    // Frame C: reset at pixel 20 abandons the frame.
    start_frame();
    while (pix_cnt < 20 && cyc < 200) tick(1'b0, 1'b1, 1'b0);
    chk("c_reached_pix20", pix_cnt, 20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    reset_frame();
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0);
    chk("c_no_done", done_cnt, 0);
    chk("c_idle_busy", oBusy, 0);

    // Frame D: clean restart from address 0.
    start_frame();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("d_first_rd_adr", first_rd_adr, 0);
    chk("d_first_vld_cyc", first_vld_cyc, 2 + RD_LAT);
    chk("d_pixels", pix_cnt, TOTAL);
    chk("d_eof_cyc", eof_cyc, 2 + RD_LAT + TOTAL - 1);
    chk("d_done_cyc", done_cyc, eof_cyc + 1);
    chk("d_done_cnt", done_cnt, 1);
    tick(1'b0, 1'b1, 1'b0);
    chk("d_busy_fall", oBusy, 0);
    chk("adr_never_over", adr_over, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
